tx_interp_cic: RTL and testbench
================================

# tx_interp_cic

Transmit-side counterpart of the DDC receiver chain. Requests baseband I/Q samples from the TX sample source once every INTERP clocks, and interpolates them to the full clock rate with a 3-stage interpolating CIC. Drives 18-bit I/Q at one sample per clock into the upconversion CORDIC. Flags underruns and overruns of the input handshake.

## Interface
Parameters:
- IN_WIDTH, 16, input sample width (signed).
- OUT_WIDTH, 18, output sample width (signed).
- INTERP, 8, interpolation factor R. Legal range 2..64.
- ACC_WIDTH, 25, width of every comb and integrator register. Must be ≥ IN_WIDTH + 3·ceil(log2 INTERP).
- OUT_SHIFT, 4, arithmetic right shift applied to the last integrator before saturation.

Ports:
- clock, in, 1: system clock (73.728 MHz).
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: TX enable (PTT); low holds the datapath cleared.
- in_req, out, 1: one-cycle strobe requesting the next input sample.
- in_valid, in, 1: qualifies in_I/in_Q for one cycle.
- in_I, in, IN_WIDTH: signed baseband I.
- in_Q, in, IN_WIDTH: signed baseband Q.
- out_I, out, OUT_WIDTH: signed interpolated I, one per clock.
- out_Q, out, OUT_WIDTH: signed interpolated Q, one per clock.
- underrun, out, 1: sticky; no sample was held at a tick.
- overrun, out, 1: sticky; a held sample was overwritten before it was consumed.

## Operation
- Phase counter cnt counts INTERP-1 down to 0, then wraps. A tick is the cycle with cnt==0 and enable=1. in_req = tick.
- Holding register (per channel) plus hold_full flag:
  - in_valid=1 stores the sample and sets hold_full.
  - in_valid=1 while hold_full=1 and not a tick: the sample overwrites, overrun is set.
- At a tick:
  - If hold_full=1: the held sample is loaded into comb input register x and hold_full clears.
  - Otherwise: x loads 0 and underrun is set.
  - If in_valid=1 on the tick cycle, the old content is consumed first, then the new sample is stored and hold_full stays 1. No overrun is flagged in this case.
- Comb section (rate 1/INTERP, advances only on ticks, M=1, 3 stages): c1 = x − x_prev, c2 = c1 − c1_prev, c3 = c2 − c2_prev. Each result is registered.
- Zero-stuffer: u = c3 in the cycle after a tick, 0 on all other cycles.
- Integrator section (every clock, 3 stages): i1 += u, i2 += i1, i3 += i2.
- All arithmetic is two's complement at ACC_WIDTH and wraps modulo 2^ACC_WIDTH. Wrap is intended, since the CIC recovers from it.
- DC gain is INTERP². Output = saturate(i3 >>> OUT_SHIFT) to the OUT_WIDTH range [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1], registered.
- enable=0:
  - cnt is held at INTERP-1; in_req stays 0.
  - Comb, integrator, hold and output registers clear synchronously; in_valid is ignored.
  - underrun and overrun clear.
- I and Q paths are identical and share cnt and hold_full.

## Timing
- Reset: cnt=INTERP-1, in_req=0, hold_full=0, all datapath registers 0, out_I=out_Q=0, underrun=0, overrun=0.
- enable rising edge: the first tick occurs INTERP-1 cycles later, i.e. cycle INTERP counting the enable-high cycle as 1.
- The producer has INTERP cycles after in_req to present in_valid before the next tick.
- Latency from the tick that loads x to the first change on out_I: 4 ticks of comb pipeline (x, c1, c2, c3) + 1 (u) + 3 (integrators) + 1 (output register). This is fixed and identical for I and Q.
- reset asserted mid-operation clears everything immediately. Release resumes with cnt=INTERP-1 and no sticky flags.
- Flags update on the tick/in_valid cycle and are visible the following cycle.

## Test plan
- DC, INTERP=8, OUT_SHIFT=4: in_I=1000, in_Q=−1000 supplied on every in_req → after ≤ 5·8+8 cycles, out_I=4000 and out_Q=−4000 on every cycle. underrun and overrun stay 0.
- Impulse: one sample in_I=16384, then zeros → out_I takes non-zero values on exactly 22 consecutive cycles. Values are 1024·{1,3,6,10,15,21,28,36,…} symmetric, and their sum is 524288.
- Saturation: in_I=32767 with OUT_SHIFT=0 → out_I pinned at 131071. in_I=−32768 → out_I pinned at −131072.
- Underrun: no in_valid for one request period → underrun=1 from the following cycle, and that period's input is treated as 0. enable low clears the flag.
- Overrun and simultaneous events:
  - Two in_valid within one period → overrun=1, and the second value is used.
  - in_valid exactly on a tick cycle → no overrun, and the new sample is used at the next tick.
- enable/reset: deassert enable mid-stream → in_req=0 and outputs are 0 the next cycle. Assert reset asynchronously mid-cycle → all outputs are 0 before the next clock edge.

Source files
------------

// File: rtl/tx_interp_cic_if.sv
// Sample-source handshake and interpolated output bus of tx_interp_cic.
// The slave modport is the interpolator's view; master is the source/sink side.
interface tx_interp_cic_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 18
);
    logic                        enable;
    logic                        in_req;
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_I;
    logic signed [IN_WIDTH-1:0]  in_Q;
    logic signed [OUT_WIDTH-1:0] out_I;
    logic signed [OUT_WIDTH-1:0] out_Q;
    logic                        underrun;
    logic                        overrun;

    modport master (
        output enable, in_valid, in_I, in_Q,
        input  in_req, out_I, out_Q, underrun, overrun
    );

    modport slave (
        input  enable, in_valid, in_I, in_Q,
        output in_req, out_I, out_Q, underrun, overrun
    );
endinterface

// File: rtl/tx_interp_cic.sv
// TX interpolator: requests one I/Q sample every INTERP clocks, holds it until
// the next tick, and interpolates to full rate with a 3-stage CIC
// (combs at the tick rate, zero-stuffer, integrators at the clock rate).
// All comb/integrator arithmetic wraps at ACC_WIDTH by design.
module tx_interp_cic #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 18,
    parameter int INTERP    = 8,
    parameter int ACC_WIDTH = 25,
    parameter int OUT_SHIFT = 4
) (
    input logic             clock,
    input logic             reset,
    tx_interp_cic_if.slave  bus
);
    localparam int CNT_W = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(INTERP - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             tick_d;
    logic             hold_full;
    logic             underrun_r;
    logic             overrun_r;

    // index 0 is I, index 1 is Q
    logic signed [IN_WIDTH-1:0]  smp     [2];
    logic signed [IN_WIDTH-1:0]  hold    [2];
    logic signed [ACC_WIDTH-1:0] x       [2];
    logic signed [ACC_WIDTH-1:0] x_prev  [2];
    logic signed [ACC_WIDTH-1:0] c1      [2];
    logic signed [ACC_WIDTH-1:0] c1_prev [2];
    logic signed [ACC_WIDTH-1:0] c2      [2];
    logic signed [ACC_WIDTH-1:0] c2_prev [2];
    logic signed [ACC_WIDTH-1:0] c3      [2];
    logic signed [ACC_WIDTH-1:0] u       [2];
    logic signed [ACC_WIDTH-1:0] i1      [2];
    logic signed [ACC_WIDTH-1:0] i2      [2];
    logic signed [ACC_WIDTH-1:0] i3      [2];
    logic signed [ACC_WIDTH-1:0] shifted [2];
    logic signed [OUT_WIDTH-1:0] sat     [2];
    logic signed [OUT_WIDTH-1:0] out_r   [2];

    assign tick         = bus.enable && (cnt == '0);
    assign bus.in_req   = tick;
    assign bus.out_I    = out_r[0];
    assign bus.out_Q    = out_r[1];
    assign bus.underrun = underrun_r;
    assign bus.overrun  = overrun_r;

    // Phase counter: down-count to zero, parked at the top while disabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= CNT_TOP;
        end else if (!bus.enable || cnt == '0) begin
            cnt <= CNT_TOP;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Route the input bus into per-channel form
    always_comb begin
        smp[0] = bus.in_I;
        smp[1] = bus.in_Q;
    end

    // Holding register and sticky handshake flags; a tick consumes before storing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold[0]    <= '0;
            hold[1]    <= '0;
            hold_full  <= 1'b0;
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else if (!bus.enable) begin
            hold[0]    <= '0;
            hold[1]    <= '0;
            hold_full  <= 1'b0;
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (tick) begin
                if (!hold_full) begin
                    underrun_r <= 1'b1;
                end
                hold_full <= bus.in_valid;
            end else if (bus.in_valid) begin
                if (hold_full) begin
                    overrun_r <= 1'b1;
                end
                hold_full <= 1'b1;
            end
            if (bus.in_valid) begin
                hold[0] <= smp[0];
                hold[1] <= smp[1];
            end
        end
    end

    // Zero-stuffer and output shift/saturation
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            u[ch]       = tick_d ? c3[ch] : '0;
            shifted[ch] = i3[ch] >>> OUT_SHIFT;
            sat[ch]     = shifted[ch][OUT_WIDTH-1:0];
            if (shifted[ch] > SAT_HI) begin
                sat[ch] = OUT_WIDTH'(SAT_HI);
            end else if (shifted[ch] < SAT_LO) begin
                sat[ch] = OUT_WIDTH'(SAT_LO);
            end
        end
    end

    // CIC datapath: combs advance on ticks, integrators and output every clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_d <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                x[ch]       <= '0;
                x_prev[ch]  <= '0;
                c1[ch]      <= '0;
                c1_prev[ch] <= '0;
                c2[ch]      <= '0;
                c2_prev[ch] <= '0;
                c3[ch]      <= '0;
                i1[ch]      <= '0;
                i2[ch]      <= '0;
                i3[ch]      <= '0;
                out_r[ch]   <= '0;
            end
        end else if (!bus.enable) begin
            tick_d <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                x[ch]       <= '0;
                x_prev[ch]  <= '0;
                c1[ch]      <= '0;
                c1_prev[ch] <= '0;
                c2[ch]      <= '0;
                c2_prev[ch] <= '0;
                c3[ch]      <= '0;
                i1[ch]      <= '0;
                i2[ch]      <= '0;
                i3[ch]      <= '0;
                out_r[ch]   <= '0;
            end
        end else begin
            tick_d <= tick;
            for (int ch = 0; ch < 2; ch++) begin
                if (tick) begin
                    x[ch]       <= hold_full
                                   ? {{(ACC_WIDTH-IN_WIDTH){hold[ch][IN_WIDTH-1]}}, hold[ch]}
                                   : '0;
                    x_prev[ch]  <= x[ch];
                    c1[ch]      <= x[ch] - x_prev[ch];
                    c1_prev[ch] <= c1[ch];
                    c2[ch]      <= c1[ch] - c1_prev[ch];
                    c2_prev[ch] <= c2[ch];
                    c3[ch]      <= c2[ch] - c2_prev[ch];
                end
                i1[ch]    <= i1[ch] + u[ch];
                i2[ch]    <= i2[ch] + i1[ch];
                i3[ch]    <= i3[ch] + i2[ch];
                out_r[ch] <= sat[ch];
            end
        end
    end
endmodule

// File: tb/tb_tx_interp_cic.sv
// Bench for tx_interp_cic: two instances (OUT_SHIFT 4 and 0) share one stimulus.
// Reference: handshake rules per cycle, output as convolution of the
// zero-stuffed tick samples with the CIC impulse response, then shift/saturate.
module tb_tx_interp_cic;
    localparam int R    = 8;
    localparam int IW   = 16;
    localparam int OW   = 18;
    localparam int AW   = 25;
    localparam int LAT  = 3 * R + 4;
    localparam int HLEN = 3 * (R - 1) + 1;
    localparam longint OMAX = 131071;
    localparam longint OMIN = -131072;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic in_valid;
    logic signed [IW-1:0] in_i;
    logic signed [IW-1:0] in_q;

    always #5 clock = ~clock;

    tx_interp_cic_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_a ();
    tx_interp_cic_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_b ();

    assign bus_a.enable   = enable;
    assign bus_a.in_valid = in_valid;
    assign bus_a.in_I     = in_i;
    assign bus_a.in_Q     = in_q;
    assign bus_b.enable   = enable;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_I     = in_i;
    assign bus_b.in_Q     = in_q;

    tx_interp_cic #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .INTERP(R), .ACC_WIDTH(AW), .OUT_SHIFT(4))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
    tx_interp_cic #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .INTERP(R), .ACC_WIDTH(AW), .OUT_SHIFT(0))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

    int     vecs = 0;
    int     errs = 0;
    int     ph;
    bit     m_hf, m_ur, m_ov;
    longint m_hi, m_hq;
    longint hist_i [64];
    longint hist_q [64];
    longint h [64];

    task automatic check(input string tag, input longint obs, input longint exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint expect_out(input bit q, input int shift);
        longint y = 0;
        for (int k = 0; k < HLEN; k++) begin
            y += h[k] * (q ? hist_q[LAT + k] : hist_i[LAT + k]);
        end
        y = y >>> shift;
        if (y > OMAX) y = OMAX;
        if (y < OMIN) y = OMIN;
        return y;
    endfunction

    task automatic model_clear();
        ph = 0; m_hf = 0; m_ur = 0; m_ov = 0; m_hi = 0; m_hq = 0;
        for (int d = 0; d < 64; d++) begin
            hist_i[d] = 0;
            hist_q[d] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit vld, input longint di, input longint dq,
                              input bit tick);
        longint li = 0, lq = 0;
        if (!en) begin
            model_clear();
            return;
        end
        if (tick) begin
            if (m_hf) begin li = m_hi; lq = m_hq; end
            else m_ur = 1;
            m_hf = vld;
        end else if (vld) begin
            if (m_hf) m_ov = 1;
            m_hf = 1;
        end
        if (vld) begin m_hi = di; m_hq = dq; end
        for (int d = 63; d > 0; d--) begin
            hist_i[d] = hist_i[d-1];
            hist_q[d] = hist_q[d-1];
        end
        hist_i[0] = li;
        hist_q[0] = lq;
        ph = tick ? 0 : ph + 1;
    endtask

    task automatic step(input bit en, input bit vld, input longint di, input longint dq);
        bit tick;
        enable   = en;
        in_valid = vld;
        in_i     = di[IW-1:0];
        in_q     = dq[IW-1:0];
        #1;
        tick = en && (ph == R - 1);
        check("in_req", bus_a.in_req, tick);
        @(posedge clock);
        model_edge(en, vld, di, dq, tick);
        #1;
        check("out_I_sh4", bus_a.out_I, expect_out(0, 4));
        check("out_Q_sh4", bus_a.out_Q, expect_out(1, 4));
        check("out_I_sh0", bus_b.out_I, expect_out(0, 0));
        check("out_Q_sh0", bus_b.out_Q, expect_out(1, 0));
        check("underrun", bus_a.underrun, m_ur);
        check("overrun", bus_a.overrun, m_ov);
    endtask

    // one sample per request period, delivered right after each tick
    task automatic feed(input int n, input longint di, input longint dq);
        for (int c = 0; c < n; c++) step(1, ph == 0, di, dq);
    endtask

    initial begin
        longint t1 [64];
        longint t2 [64];
        int nz, first, last;
        longint sum;

        for (int n = 0; n < 64; n++) t1[n] = (n < R) ? 1 : 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 64; n++) begin
                t2[n] = 0;
                for (int j = 0; j < R; j++) if (n - j >= 0) t2[n] += t1[n-j];
            end
            t1 = t2;
        end
        h = t1;

        reset = 1; enable = 0; in_valid = 0; in_i = 0; in_q = 0;
        model_clear();
        #3;
        check("rst_out_I", bus_a.out_I, 0);
        check("rst_out_Q", bus_a.out_Q, 0);
        check("rst_in_req", bus_a.in_req, 0);
        check("rst_underrun", bus_a.underrun, 0);
        check("rst_overrun", bus_a.overrun, 0);
        @(posedge clock); #1;
        reset = 0;
        step(0, 0, 0, 0);

        // DC
        feed(70, 1000, -1000);
        check("dc_out_I", bus_a.out_I, 4000);
        check("dc_out_Q", bus_a.out_Q, -4000);
        check("dc_underrun", bus_a.underrun, 0);
        check("dc_overrun", bus_a.overrun, 0);

        // asynchronous reset in the middle of a cycle
        #2 reset = 1;
        #1;
        check("arst_out_I", bus_a.out_I, 0);
        check("arst_out_Q", bus_a.out_Q, 0);
        check("arst_in_req", bus_a.in_req, 0);
        @(posedge clock); #1;
        reset = 0;
        model_clear();

        // impulse
        step(0, 0, 0, 0);
        nz = 0; sum = 0; first = -1; last = -1;
        for (int c = 0; c < 100; c++) begin
            step(1, ph == 0, (c == 0) ? 16384 : 0, 0);
            if (bus_a.out_I != 0) begin
                nz++;
                sum += longint'(bus_a.out_I);
                if (first < 0) first = c;
                last = c;
            end
        end
        check("imp_count", nz, 22);
        check("imp_span", last - first + 1, 22);
        check("imp_sum", sum, 524288);

        // saturation
        step(0, 0, 0, 0);
        feed(70, 32767, -32768);
        check("sat_hi_I", bus_b.out_I, OMAX);
        check("sat_lo_Q", bus_b.out_Q, OMIN);
        feed(70, -32768, 32767);
        check("sat_lo_I", bus_b.out_I, OMIN);
        check("sat_hi_Q", bus_b.out_Q, OMAX);

        // underrun: skip one whole period
        step(0, 0, 0, 0);
        feed(30, 500, 700);
        while (ph != 0) step(1, 0, 0, 0);
        for (int c = 0; c < R; c++) step(1, 0, 0, 0);
        check("underrun_set", bus_a.underrun, 1);
        feed(40, 500, 700);
        step(0, 0, 0, 0);
        check("underrun_clr", bus_a.underrun, 0);
        check("enable_off_req", bus_a.in_req, 0);
        check("enable_off_out", bus_a.out_I, 0);

        // overrun: two samples in one period, second wins
        feed(20, 300, 300);
        while (ph != 0) step(1, 0, 0, 0);
        for (int c = 0; c < R; c++) step(1, c == 0 || c == 3, (c == 0) ? 9000 : -6000, 100 * c);
        check("overrun_set", bus_a.overrun, 1);
        feed(50, 0, 0);

        // sample on the tick cycle: no overrun, used at the next tick
        step(0, 0, 0, 0);
        step(1, 1, 5000, -5000);
        while (ph != R - 1) step(1, 0, 0, 0);
        step(1, 1, 7000, -7000);
        for (int c = 0; c < R; c++) step(1, 0, 0, 0);
        check("tickvld_overrun", bus_a.overrun, 0);
        check("tickvld_underrun", bus_a.underrun, 0);
        feed(50, 0, 0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 5) == 0,
                 longint'($urandom_range(0, 65535)) - 32768,
                 longint'($urandom_range(0, 65535)) - 32768);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
